// File: rtl/instr_seq_ctrl.sv
// Multi-cycle instruction sequencer: steps each instruction through
// FETCH/DECODE/EXECUTE/MEM/WB, owns the architectural PC and retirement counters.
module instr_seq_ctrl #(
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h01000000)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  input  logic              imem_ack_i,
  output logic              dec_load_o,
  input  logic [6:0]        opcode_i,
  output logic              exec_en_o,
  input  logic              br_taken_i,
  input  logic [AWIDTH-1:0] br_target_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  input  logic              dmem_ack_i,
  output logic              rf_we_o,
  output logic [AWIDTH-1:0] pc_o,
  output logic              halted_o,
  output logic              error_o,
  output logic [31:0]       cycle_cnt_o,
  output logic [31:0]       retired_cnt_o
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_JUMP, C_BRANCH, C_LOAD, C_STORE
  } cls_t;

  state_t            state_q, state_d;
  cls_t              cls_q, cls_d;
  logic              redirect_q, redirect_d;
  logic [AWIDTH-1:0] target_q, target_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic              error_q, error_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [31:0]       retired_q, retired_d;
  logic              retire;
  logic              redirect_now;

  assign redirect_now = (cls_q == C_JUMP) || ((cls_q == C_BRANCH) && br_taken_i);

  // Fresh redirect/target are used when retiring straight out of EXECUTE (branches).
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    redirect_d = redirect_q;
    target_d   = target_q;
    error_d    = error_q;
    retire     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (imem_ack_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
        case (opcode_i)
          7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011: cls_d = C_ALU;
          7'b1101111, 7'b1100111:                         cls_d = C_JUMP;
          7'b1100011:                                     cls_d = C_BRANCH;
          7'b0000011:                                     cls_d = C_LOAD;
          7'b0100011:                                     cls_d = C_STORE;
          7'b1110011:                                     state_d = S_HALT;
          default: begin
            state_d = S_HALT;
            error_d = 1'b1;
          end
        endcase
      end
      S_EXECUTE: begin
        target_d   = br_target_i;
        redirect_d = redirect_now;
        if (redirect_now && (br_target_i[1:0] != 2'b00)) begin
          state_d = S_HALT;
          error_d = 1'b1;
        end else begin
          case (cls_q)
            C_LOAD, C_STORE: state_d = S_MEM;
            C_BRANCH: begin
              retire  = 1'b1;
              state_d = S_FETCH;
            end
            default: state_d = S_WB;
          endcase
        end
      end
      S_MEM: begin
        if (dmem_ack_i) begin
          if (cls_q == C_LOAD) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase

    pc_d      = retire ? (redirect_d ? target_d : pc_q + AWIDTH'(4)) : pc_q;
    retired_d = retire ? retired_q + 32'd1 : retired_q;
    cycle_d   = (state_q != S_HALT) ? cycle_q + 32'd1 : cycle_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      cls_q      <= C_ALU;
      redirect_q <= 1'b0;
      target_q   <= '0;
      pc_q       <= BASEADDR;
      error_q    <= 1'b0;
      cycle_q    <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
      pc_q       <= pc_d;
      error_q    <= error_d;
      cycle_q    <= cycle_d;
      retired_q  <= retired_d;
    end
  end

  // Reset sits in FETCH, so the fetch request is masked while reset is held.
  assign imem_req_o    = rst && (state_q == S_FETCH);
  assign dec_load_o    = imem_req_o && imem_ack_i;
  assign exec_en_o     = (state_q == S_EXECUTE);
  assign dmem_req_o    = (state_q == S_MEM);
  assign dmem_we_o     = (state_q == S_MEM) && (cls_q == C_STORE);
  assign rf_we_o       = (state_q == S_WB);
  assign halted_o      = (state_q == S_HALT);
  assign error_o       = error_q;
  assign pc_o          = pc_q;
  assign cycle_cnt_o   = cycle_q;
  assign retired_cnt_o = retired_q;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Self-checking bench for instr_seq_ctrl: directed scenarios followed by random
// instructions, compared against a per-instruction cost/PC model.
module tb_instr_seq_ctrl;

  localparam logic [31:0] BASE = 32'h01000000;

  localparam int K_ALU = 0, K_JUMP = 1, K_BRANCH = 2, K_LOAD = 3, K_STORE = 4,
                 K_SYS = 5, K_ILL = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_o, imem_ack_i, dec_load_o, exec_en_o, br_taken_i;
  logic        dmem_req_o, dmem_we_o, dmem_ack_i, rf_we_o, halted_o, error_o;
  logic [6:0]  opcode_i;
  logic [31:0] br_target_i, pc_o, cycle_cnt_o, retired_cnt_o;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [31:0] m_pc, m_cycles, m_retired;
  logic        m_halt, m_err;

  instr_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i), .dec_load_o(dec_load_o),
    .opcode_i(opcode_i), .exec_en_o(exec_en_o), .br_taken_i(br_taken_i),
    .br_target_i(br_target_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_ack_i(dmem_ack_i), .rf_we_o(rf_we_o), .pc_o(pc_o), .halted_o(halted_o),
    .error_o(error_o), .cycle_cnt_o(cycle_cnt_o), .retired_cnt_o(retired_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int classify(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011: return K_ALU;
      7'b1101111, 7'b1100111:                         return K_JUMP;
      7'b1100011:                                     return K_BRANCH;
      7'b0000011:                                     return K_LOAD;
      7'b0100011:                                     return K_STORE;
      7'b1110011:                                     return K_SYS;
      default:                                        return K_ILL;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = BASE; m_cycles = 0; m_retired = 0; m_halt = 0; m_err = 0;
  endtask

  task automatic check_arch(input string tag);
    check({tag, "_pc"}, pc_o, m_pc);
    check({tag, "_retired"}, retired_cnt_o, m_retired);
    check({tag, "_cycles"}, cycle_cnt_o, m_cycles);
    check({tag, "_halted"}, halted_o, m_halt);
    check({tag, "_error"}, error_o, m_err);
  endtask

  // Holds reset for two cycles, checks the reset state, releases at a negedge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; imem_ack_i = 0; dmem_ack_i = 0; br_taken_i = 0;
    opcode_i = 7'b0010011; br_target_i = 0;
    repeat (2) @(negedge clk);
    model_reset();
    check("reset_outputs", {imem_req_o, dec_load_o, exec_en_o, dmem_req_o, dmem_we_o, rf_we_o}, 6'b0);
    check_arch("reset");
    rst = 1'b1;
    #1;
  endtask

  // Runs one instruction from its first FETCH cycle until the next FETCH or HALT.
  task automatic run_instr(input logic [6:0] op, input logic tk, input logic [31:0] tgt,
                           input int iw, input int dw, input bit stray);
    int cyc = 0, fetch_w = 0, mem_w = 0;
    int n_dec = 0, n_exec = 0, n_dmem = 0, n_we = 0, n_rf = 0;
    bit left_fetch = 0, done = 0;
    int c, e_cyc, e_dmem, e_we, e_rf;
    bit redir, mis;
    opcode_i = op; br_taken_i = tk; br_target_i = tgt;
    for (int k = 0; k < 300 && !done; k++) begin
      if (halted_o) done = 1;
      else if (left_fetch && imem_req_o) done = 1;
      else begin
        imem_ack_i = 0; dmem_ack_i = 0;
        if (imem_req_o) begin
          imem_ack_i = (fetch_w == iw);
          fetch_w++;
        end else begin
          left_fetch = 1;
          if (stray) imem_ack_i = 1'($urandom_range(0, 1));
        end
        if (dmem_req_o) begin
          dmem_ack_i = (mem_w == dw);
          mem_w++; n_dmem++;
          if (dmem_we_o) n_we++;
        end else if (stray) dmem_ack_i = 1'($urandom_range(0, 1));
        n_exec += int'(exec_en_o);
        n_rf   += int'(rf_we_o);
        #1 n_dec += int'(dec_load_o);
        cyc++;
        @(negedge clk); #1;
      end
    end
    imem_ack_i = 0; dmem_ack_i = 0;
    check("instr_completed", done, 1);

    c     = classify(op);
    redir = (c == K_JUMP) || (c == K_BRANCH && tk);
    mis   = redir && (tgt[1:0] != 2'b00);
    e_cyc = iw + 2;
    e_dmem = 0; e_we = 0; e_rf = 0;
    if (c == K_SYS || c == K_ILL) begin
      m_halt = 1; m_err = (c == K_ILL);
    end else begin
      e_cyc += 1;
      if (mis) begin
        m_halt = 1; m_err = 1;
      end else begin
        if (c == K_LOAD)  begin e_cyc += dw + 2; e_dmem = dw + 1; e_rf = 1; end
        if (c == K_STORE) begin e_cyc += dw + 1; e_dmem = dw + 1; e_we = dw + 1; end
        if (c == K_ALU || c == K_JUMP) begin e_cyc += 1; e_rf = 1; end
        m_pc = redir ? tgt : m_pc + 32'd4;
        m_retired++;
      end
    end
    m_cycles += e_cyc;

    check("instr_cycles", cyc, e_cyc);
    check("dec_load_pulses", n_dec, 1);
    check("exec_en_cycles", n_exec, (c == K_SYS || c == K_ILL) ? 0 : 1);
    check("dmem_req_cycles", n_dmem, e_dmem);
    check("dmem_we_cycles", n_we, e_we);
    check("rf_we_cycles", n_rf, e_rf);
    check_arch("after_instr");
  endtask

  // In HALT, acks are ignored and everything stays frozen.
  task automatic halt_hold();
    for (int k = 0; k < 5; k++) begin
      imem_ack_i = 1'($urandom_range(0, 1));
      dmem_ack_i = 1'($urandom_range(0, 1));
      #1;
      check("halt_outputs", {imem_req_o, dec_load_o, exec_en_o, dmem_req_o, dmem_we_o, rf_we_o}, 6'b0);
      @(negedge clk); #1;
    end
    imem_ack_i = 0; dmem_ack_i = 0;
    check_arch("halt_frozen");
  endtask

  initial begin
    bit seen;
    int r;
    logic [6:0]  op;
    logic [31:0] tgt;
    logic [6:0]  alu_ops [4] = '{7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011};

    do_reset();
    check("first_fetch_req", imem_req_o, 1);
    run_instr(7'b0010011, 0, 32'h0, 0, 0, 0);
    run_instr(7'b0000011, 0, 32'h0, 0, 3, 0);
    run_instr(7'b1100011, 1, 32'h01000040, 0, 0, 0);
    run_instr(7'b1100011, 0, 32'h01000080, 0, 0, 0);
    run_instr(7'b0100011, 0, 32'h0, 1, 1, 1);
    run_instr(7'b1100111, 0, 32'h01000100, 0, 0, 1);
    run_instr(7'b0010111, 0, 32'h0, 2, 0, 1);
    run_instr(7'b1101111, 0, 32'h01000022, 0, 0, 0);
    halt_hold();

    do_reset();
    run_instr(7'b0000000, 0, 32'h0, 0, 0, 0);
    halt_hold();
    do_reset();
    run_instr(7'b1110011, 0, 32'h0, 1, 0, 1);
    halt_hold();

    do_reset();
    run_instr(7'b1101111, 0, 32'hFFFFFFFC, 0, 0, 0);
    run_instr(7'b0110011, 0, 32'h0, 0, 0, 0);

    // Asynchronous reset in the middle of a data access.
    do_reset();
    opcode_i = 7'b0000011;
    imem_ack_i = 1;
    @(negedge clk); #1;
    imem_ack_i = 0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (dmem_req_o) seen = 1;
      else begin @(negedge clk); #1; end
    end
    check("mem_reached", seen, 1);
    #1 rst = 1'b0;
    #1;
    model_reset();
    check("async_reset_outputs", {imem_req_o, dmem_req_o, dmem_we_o, exec_en_o, rf_we_o}, 5'b0);
    check_arch("async_reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("fetch_resumes", imem_req_o, 1);
    run_instr(7'b0010011, 0, 32'h0, 0, 0, 0);

    for (int n = 0; n < 50; n++) begin
      if (m_halt) begin
        halt_hold();
        do_reset();
      end
      r = $urandom_range(0, 19);
      if (r < 4)       op = alu_ops[r];
      else if (r == 4) op = 7'b1101111;
      else if (r == 5) op = 7'b1100111;
      else if (r < 9)  op = 7'b1100011;
      else if (r < 12) op = 7'b0000011;
      else if (r < 15) op = 7'b0100011;
      else if (r == 15) op = 7'b1110011;
      else if (r == 16) op = 7'($urandom);
      else              op = alu_ops[r - 17];
      tgt = $urandom() & 32'hFFFFFFFC;
      if ($urandom_range(0, 7) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      run_instr(op, 1'($urandom_range(0, 1)), tgt, $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
